// File: rtl/pipe_chain_v.sv
// rtl/pipe_chain_v.sv - elastic DEPTH-stage valid/ready delay pipeline with bubble collapsing
// Stalls propagate backward only as far as the nearest empty stage, so bubbles are squeezed out.
module pipe_chain_v #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             o_ready,
  output logic [CW-1:0]    o_count
);

  logic [DEPTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] up_v;
  logic [WIDTH-1:0] up_d [DEPTH];
  logic             in_hs, out_hs;

  // Stage k may load when any stage at or after it is empty, or the consumer takes the head.
  always_comb begin
    rdy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      rdy[k] = o_ready;
      for (int j = k; j < DEPTH; j++) begin
        if (!v_q[j]) rdy[k] = 1'b1;
      end
    end
  end

  always_comb begin
    up_v[0] = i_valid;
    up_d[0] = i_data;
    for (int k = 1; k < DEPTH; k++) begin
      up_v[k] = v_q[k-1];
      up_d[k] = d_q[k-1];
    end
  end

  assign i_ready = en & ~flush & ~rst & rdy[0];
  assign o_valid = en & v_q[DEPTH-1];
  assign o_data  = d_q[DEPTH-1];
  assign o_count = count_q;
  assign in_hs   = i_valid & i_ready;
  assign out_hs  = o_valid & o_ready;

  always_comb begin
    v_d     = v_q;
    d_d     = d_q;
    count_d = count_q;
    if (flush) begin
      v_d     = '0;
      count_d = '0;
    end else if (en) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (rdy[k]) begin
          v_d[k] = up_v[k];
          if (up_v[k]) d_d[k] = up_d[k];
        end
      end
      count_d = count_q + CW'(in_hs) - CW'(out_hs);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q     <= '0;
      count_q <= '0;
      for (int k = 0; k < DEPTH; k++) d_q[k] <= '0;
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      d_q     <= d_d;
    end
  end

  a_count_range: assert property (@(posedge clk) count_q <= CW'(DEPTH));
  a_hold_stall:  assert property (@(posedge clk) (o_valid && !o_ready && !rst) |=> $stable(o_data));

endmodule

// File: tb/tb_pipe_chain_v.sv
// tb/tb_pipe_chain_v.sv - scoreboard bench for pipe_chain_v against a sample-position model
module tb_pipe_chain_v;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic             clk, rst, en, flush, i_valid, o_ready;
  logic [WIDTH-1:0] i_data;
  logic             i_ready, o_valid;
  logic [WIDTH-1:0] o_data;
  logic [2:0]       o_count;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 0;

  // Model: pos_q holds the stage position of each in-flight sample, oldest first;
  // exp_q is the scoreboard of accepted data awaiting output.
  int               pos_q[$];
  int               np[$];
  logic [WIDTH-1:0] exp_q[$];
  bit               acc;

  pipe_chain_v #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .i_valid(i_valid), .i_data(i_data), .i_ready(i_ready),
    .o_valid(o_valid), .o_data(o_data), .o_ready(o_ready),
    .o_count(o_count)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // A sample moves up one stage when an empty stage exists above it or the head is consumed.
  always @(posedge clk) begin
    if (rst || flush) begin
      pos_q.delete();
      exp_q.delete();
    end else if (en) begin
      acc = i_valid && (pos_q.size() < DEPTH || o_ready);
      np.delete();
      foreach (pos_q[i]) begin
        if (o_ready || (i < DEPTH - 1 - pos_q[i])) begin
          if (pos_q[i] + 1 < DEPTH) np.push_back(pos_q[i] + 1);
        end else begin
          np.push_back(pos_q[i]);
        end
      end
      if (acc) begin
        np.push_back(0);
        exp_q.push_back(i_data);
      end
      pos_q = np;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("i_ready", 32'(i_ready),
            32'(!rst && !flush && en && (pos_q.size() < DEPTH || o_ready)));
      check("o_valid", 32'(o_valid),
            32'(en && (pos_q.size() > 0 ? pos_q[0] == DEPTH - 1 : 1'b0)));
      check("o_count", 32'(o_count), 32'(pos_q.size()));
    end
  end

  always @(negedge clk) begin
    if (chk_on && o_valid && o_ready) begin
      if (exp_q.size() == 0) check("unexpected_output", 32'(o_data), 32'hFFFF_FFFF);
      else check("o_data", 32'(o_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [WIDTH-1:0] d);
    bit done = 0;
    i_valid = 1;
    i_data  = d;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      done = i_ready;
      @(posedge clk);
      #1;
    end
    i_valid = 0;
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int  lat;
    bit  found;
    rst = 1; en = 1; flush = 0; i_valid = 0; i_data = '0; o_ready = 0;
    tick(2);
    @(negedge clk);
    check("rst_o_valid", 32'(o_valid), 32'd0);
    check("rst_o_data", 32'(o_data), 32'd0);
    check("rst_o_count", 32'(o_count), 32'd0);
    check("rst_i_ready", 32'(i_ready), 32'd0);
    chk_on = 1;
    @(posedge clk); #1;
    rst = 0;

    // back-to-back stream at full rate
    o_ready = 1;
    for (int n = 1; n <= 16; n++) send(WIDTH'(n));
    tick(DEPTH + 2);

    // fill with consumer stalled, then release
    o_ready = 0;
    for (int n = 0; n < 4; n++) send(16'hA000 + WIDTH'(n));
    i_valid = 1; i_data = 16'hA004;
    tick(6);
    @(negedge clk);
    check("full_head", 32'(o_data), 32'h0000_A000);
    check("full_i_ready", 32'(i_ready), 32'd0);
    @(posedge clk); #1;
    i_valid = 0; o_ready = 1;
    tick(8);

    // input bubbles with random consumer
    for (int c = 0; c < 40; c++) begin
      i_valid = (c % 2 == 0);
      i_data  = WIDTH'($urandom);
      o_ready = 1'($urandom % 2);
      tick(1);
    end
    i_valid = 0; o_ready = 1;
    tick(8);

    // flush with three in flight
    o_ready = 0;
    send(16'h0B01); send(16'h0B02); send(16'h0B03);
    flush = 1;
    tick(1);
    flush = 0;
    @(negedge clk);
    check("flush_count", 32'(o_count), 32'd0);
    check("flush_valid", 32'(o_valid), 32'd0);
    @(posedge clk); #1;
    o_ready = 1;
    send(16'h1234);
    lat = 0; found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      lat++;
      if (o_valid) found = 1;
    end
    check("flush_latency", 32'(lat), 32'(DEPTH));
    @(posedge clk); #1;
    tick(4);

    // enable freeze mid-stream
    o_ready = 1;
    for (int c = 0; c < 4; c++) begin
      i_valid = 1; i_data = WIDTH'($urandom);
      tick(1);
    end
    en = 0;
    tick(5);
    @(negedge clk);
    check("freeze_o_valid", 32'(o_valid), 32'd0);
    @(posedge clk); #1;
    en = 1;
    for (int c = 0; c < 4; c++) begin
      i_data = WIDTH'($urandom);
      tick(1);
    end
    i_valid = 0;
    tick(8);

    // reset with two samples held
    o_ready = 0;
    send(16'h0C01); send(16'h0C02);
    rst = 1;
    tick(1);
    @(negedge clk);
    check("rst2_o_valid", 32'(o_valid), 32'd0);
    check("rst2_o_data", 32'(o_data), 32'd0);
    check("rst2_o_count", 32'(o_count), 32'd0);
    check("rst2_i_ready", 32'(i_ready), 32'd0);
    @(posedge clk); #1;
    rst = 0;

    // random soak
    for (int c = 0; c < 300; c++) begin
      en      = ($urandom % 8) != 0;
      flush   = ($urandom % 32) == 0;
      i_valid = 1'($urandom % 2);
      i_data  = WIDTH'($urandom);
      o_ready = 1'($urandom % 2);
      tick(1);
    end
    en = 1; flush = 0; i_valid = 0; o_ready = 1;
    tick(DEPTH + 4);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
